// File: rtl/lr3_seq_check_p.sv
// Sequence checker: digits entered on CE are compared against a programmable
// expected sequence, with checkpoint rollback on mismatch and lockout after MAX_ERR errors.
module lr3_seq_check_p #(
    parameter int DW      = 4,
    parameter int DEPTH   = 16,
    parameter int GROUP   = 4,
    parameter int NDISP   = 4,
    parameter int MAX_ERR = 3,
    localparam int AW     = $clog2(DEPTH),
    localparam int EW     = $clog2(MAX_ERR + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 CLR,
    input  logic [DW-1:0]        DAT_I,
    input  logic                 PRG_WE,
    input  logic [AW-1:0]        PRG_ADDR,
    input  logic [DW-1:0]        PRG_DAT,
    output logic [8*NDISP-1:0]   DISP_SEQ,
    output logic [2*NDISP-1:0]   DISP_OFF,
    output logic                 DONE,
    output logic                 LOCK,
    output logic [EW-1:0]        ERR_CNT,
    output logic [AW-1:0]        POS
);

    typedef enum logic [1:0] {
        ST_CHECK  = 2'd0,
        ST_DONE   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [NDISP-1:0] OFF_ONE = ~(NDISP'(1));
    localparam logic [NDISP-1:0] OFF_ALL = {NDISP{1'b1}};
    localparam logic [AW:0]      GMASK   = (AW+1)'(GROUP - 1);
    localparam logic [AW-1:0]    LAST    = AW'(DEPTH - 1);
    localparam logic [EW-1:0]    ERR_MAX = EW'(MAX_ERR);

    logic [DEPTH-1:0][DW-1:0] seq_q;
    state_e                   state_q, state_d;
    logic [AW-1:0]            pos_q, pos_d, chk_q, chk_d;
    logic [EW-1:0]            err_q, err_d, err_inc;
    logic [4*NDISP-1:0]       wait_q, wait_d, log_q, log_d;
    logic [NDISP-1:0]         woff_q, woff_d, loff_q, loff_d;
    logic                     done_q, lock_q;
    logic [AW:0]              pos_inc;
    logic [3:0]               dat_nib, nxt_nib;

    function automatic logic [3:0] to_nib(input logic [DW-1:0] d);
        logic [3:0] r;
        r = 4'b0;
        r[DW-1:0] = d;
        return r;
    endfunction

    function automatic logic [4*NDISP-1:0] shift_in(input logic [4*NDISP-1:0] v,
                                                    input logic [3:0] n);
        logic [4*NDISP-1:0] r;
        r = v << 3'd4;
        r[3:0] = n;
        return r;
    endfunction

    assign pos_inc = {1'b0, pos_q} + {{AW{1'b0}}, 1'b1};
    assign err_inc = err_q + {{(EW-1){1'b0}}, 1'b1};
    assign dat_nib = to_nib(DAT_I);
    assign nxt_nib = (pos_q == LAST) ? 4'b0 : to_nib(seq_q[pos_inc[AW-1:0]]);

    // Next-state computation; CLR outranks programming, which outranks digit entry.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        chk_d   = chk_q;
        err_d   = err_q;
        wait_d  = wait_q;
        woff_d  = woff_q;
        log_d   = log_q;
        loff_d  = loff_q;
        if (CLR) begin
            state_d = ST_CHECK;
            pos_d   = '0;
            chk_d   = '0;
            err_d   = '0;
            wait_d  = shift_in('0, to_nib(seq_q[0]));
            woff_d  = OFF_ONE;
            log_d   = '0;
            loff_d  = OFF_ALL;
        end else if (!PRG_WE && CE && (state_q == ST_CHECK)) begin
            log_d  = shift_in(log_q, dat_nib);
            loff_d = loff_q << 1'b1;
            if (DAT_I == seq_q[pos_q]) begin
                wait_d = shift_in(wait_q, nxt_nib);
                woff_d = (woff_q == '0) ? OFF_ONE : (woff_q << 1'b1);
                if (pos_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pos_d = pos_inc[AW-1:0];
                    if ((pos_inc & GMASK) == '0) begin
                        chk_d = pos_inc[AW-1:0];
                    end else begin
                        chk_d = chk_q;
                    end
                end
            end else begin
                // Roll back to the last checkpoint and show its digit as the next one to enter.
                pos_d  = chk_q;
                wait_d = shift_in('0, to_nib(seq_q[chk_q]));
                woff_d = OFF_ONE;
                err_d  = err_inc;
                if (err_inc == ERR_MAX) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = state_q;
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // Control state, counters and display registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_CHECK;
            pos_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            wait_q  <= '0;
            woff_q  <= OFF_ONE;
            log_q   <= '0;
            loff_q  <= OFF_ALL;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            woff_q  <= woff_d;
            log_q   <= log_d;
            loff_q  <= loff_d;
            done_q  <= (state_d == ST_DONE);
            lock_q  <= (state_d == ST_LOCKED);
        end
    end

    // Expected-sequence register file, writable in every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seq_q <= '0;
        end else if (PRG_WE) begin
            seq_q[PRG_ADDR] <= PRG_DAT;
        end
    end

    assign DISP_SEQ = {wait_q, log_q};
    assign DISP_OFF = {woff_q, loff_q};
    assign DONE     = done_q;
    assign LOCK     = lock_q;
    assign ERR_CNT  = err_q;
    assign POS      = pos_q;

endmodule

// File: tb/tb_lr3_seq_check_p.sv
// Scoreboard bench for lr3_seq_check_p: a digit-level reference model queues the
// expected outputs per cycle and a monitor compares them against the DUT.
module tb_lr3_seq_check_p;

    localparam int DW = 4, DEPTH = 8, GROUP = 4, NDISP = 4, MAX_ERR = 3;

    logic        clk = 1'b0;
    logic        RST = 1'b1, CE = 1'b0, CLR = 1'b0, PRG_WE = 1'b0;
    logic [3:0]  DAT_I = 4'd0, PRG_DAT = 4'd0;
    logic [2:0]  PRG_ADDR = 3'd0;
    logic [31:0] DISP_SEQ;
    logic [7:0]  DISP_OFF;
    logic        DONE, LOCK;
    logic [1:0]  ERR_CNT;
    logic [2:0]  POS;

    lr3_seq_check_p #(.DW(DW), .DEPTH(DEPTH), .GROUP(GROUP), .NDISP(NDISP), .MAX_ERR(MAX_ERR)) dut (
        .CLK(clk), .RST(RST), .CE(CE), .CLR(CLR), .DAT_I(DAT_I),
        .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .PRG_DAT(PRG_DAT),
        .DISP_SEQ(DISP_SEQ), .DISP_OFF(DISP_OFF), .DONE(DONE), .LOCK(LOCK),
        .ERR_CNT(ERR_CNT), .POS(POS)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [46:0] sb[$];

    // Reference model: digits and blank flags held per display position (index 0 = rightmost).
    int m_seq[DEPTH];
    int m_pos, m_chk, m_err, m_state;   // state: 0 checking, 1 done, 2 locked
    int wdig[NDISP], woff[NDISP], ldig[NDISP], loff[NDISP];

    function automatic void wait_single(input int dig);
        for (int i = 0; i < NDISP; i++) begin
            wdig[i] = 0;
            woff[i] = 1;
        end
        wdig[0] = dig;
        woff[0] = 0;
    endfunction

    function automatic void model_step(input bit rst, clr, we, input int addr, pd,
                                       input bit ce, input int d);
        int old0, nd, offsum;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_seq[i] = 0;
            m_pos = 0; m_chk = 0; m_err = 0; m_state = 0;
            wait_single(0);
            for (int i = 0; i < NDISP; i++) begin
                ldig[i] = 0;
                loff[i] = 1;
            end
            return;
        end
        old0 = m_seq[0];
        if (we) m_seq[addr] = pd;
        if (clr) begin
            m_pos = 0; m_chk = 0; m_err = 0; m_state = 0;
            wait_single(old0);
            for (int i = 0; i < NDISP; i++) begin
                ldig[i] = 0;
                loff[i] = 1;
            end
        end else if (!we && ce && m_state == 0) begin
            for (int i = NDISP - 1; i > 0; i--) begin
                ldig[i] = ldig[i-1];
                loff[i] = loff[i-1];
            end
            ldig[0] = d;
            loff[0] = 0;
            if (d == m_seq[m_pos]) begin
                nd = (m_pos == DEPTH - 1) ? 0 : m_seq[m_pos + 1];
                offsum = 0;
                for (int i = 0; i < NDISP; i++) offsum += woff[i];
                for (int i = NDISP - 1; i > 0; i--) wdig[i] = wdig[i-1];
                wdig[0] = nd;
                if (offsum == 0) begin
                    woff[0] = 0;
                    for (int i = 1; i < NDISP; i++) woff[i] = 1;
                end else begin
                    for (int i = NDISP - 1; i > 0; i--) woff[i] = woff[i-1];
                    woff[0] = 0;
                end
                if (m_pos == DEPTH - 1) m_state = 1;
                else begin
                    m_pos++;
                    if (m_pos % GROUP == 0) m_chk = m_pos;
                end
            end else begin
                m_pos = m_chk;
                wait_single(m_seq[m_chk]);
                m_err++;
                if (m_err == MAX_ERR) m_state = 2;
            end
        end
    endfunction

    function automatic logic [46:0] model_out();
        logic [15:0] w, l;
        logic [3:0]  wo, lo;
        for (int i = 0; i < NDISP; i++) begin
            w[4*i +: 4] = 4'(wdig[i]);
            l[4*i +: 4] = 4'(ldig[i]);
            wo[i] = (woff[i] != 0);
            lo[i] = (loff[i] != 0);
        end
        return {w, l, wo, lo, (m_state == 1), (m_state == 2), 2'(m_err), 3'(m_pos)};
    endfunction

    task automatic step(input bit rst, clr, we, input int addr, pd, input bit ce, input int d);
        @(negedge clk);
        RST = rst; CLR = clr; PRG_WE = we; PRG_ADDR = 3'(addr); PRG_DAT = 4'(pd);
        CE = ce; DAT_I = 4'(d);
        @(posedge clk);
        #1;
        model_step(rst, clr, we, addr, pd, ce, d);
        sb.push_back(model_out());
    endtask

    task automatic enter(input int d);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, d);
    endtask

    task automatic check_const(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every negedge, compare the DUT against all expectations queued so far.
    initial begin
        logic [46:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {DISP_SEQ, DISP_OFF, DONE, LOCK, ERR_CNT, POS};
                n_vec++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: got seq=%h off=%h done=%b lock=%b err=%0d pos=%0d expected seq=%h off=%h done=%b lock=%b err=%0d pos=%0d",
                             $time, act_v[46:15], act_v[14:7], act_v[6], act_v[5], act_v[4:3], act_v[2:0],
                             exp_v[46:15], exp_v[14:7], exp_v[6], exp_v[5], exp_v[4:3], exp_v[2:0]);
                end
            end
        end
    end

    initial begin
        int r, d;
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        check_const("reset_disp_seq", DISP_SEQ, 32'h0);
        check_const("reset_disp_off", {24'h0, DISP_OFF}, 32'hEF);
        check_const("reset_flags", {27'h0, DONE, LOCK, ERR_CNT, POS}, 32'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, i, i + 1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        check_const("clr_disp_seq", DISP_SEQ, 32'h0001_0000);
        enter(1); enter(2); enter(3);
        check_const("after123_seq", DISP_SEQ, 32'h1234_0123);
        check_const("after123_off", {24'h0, DISP_OFF}, 32'h08);
        enter(4);
        check_const("after4_seq", DISP_SEQ, 32'h2345_1234);
        check_const("after4_off", {24'h0, DISP_OFF}, 32'hE0);
        enter(9);
        check_const("after9_seq", DISP_SEQ, 32'h0005_2349);
        check_const("after9_flags", {27'h0, DONE, LOCK, ERR_CNT, POS}, {27'h0, 1'b0, 1'b0, 2'd1, 3'd4});
        enter(5); enter(6); enter(7); enter(8);
        check_const("done_seq", DISP_SEQ, 32'h6780_5678);
        check_const("done_flags", {27'h0, DONE, LOCK, ERR_CNT, POS}, {27'h0, 1'b1, 1'b0, 2'd1, 3'd7});
        enter(3);
        check_const("done_frozen", DISP_SEQ, 32'h6780_5678);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        enter(9); enter(9); enter(9);
        check_const("lock_flags", {27'h0, DONE, LOCK, ERR_CNT, POS}, {27'h0, 1'b0, 1'b1, 2'd3, 3'd0});
        enter(1);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        check_const("unlock_seq", DISP_SEQ, 32'h0001_0000);
        check_const("unlock_flags", {27'h0, DONE, LOCK, ERR_CNT, POS}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 0, 7, 1'b1, 1);
        check_const("clr_we_same_cycle", DISP_SEQ, 32'h0001_0000);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        check_const("clr_after_write", DISP_SEQ, 32'h0007_0000);
        enter(7); enter(2);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        check_const("midrst_off", {24'h0, DISP_OFF}, 32'hEF);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        check_const("rst_cleared_seq", DISP_SEQ, 32'h0);

        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, i, $urandom_range(0, 15), 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 3) != 0) ? m_seq[m_pos] : $urandom_range(0, 15);
            if (r < 2)       step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
            else if (r < 7)  step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0);
            else if (r < 11) step(1'b0, 1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 15), 1'b0, 0);
            else if (r < 13) step(1'b0, 1'b1, 1'b1, $urandom_range(0, 7), $urandom_range(0, 15), 1'b1, d);
            else if (r < 15) step(1'b0, 1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 15), 1'b1, d);
            else if (r < 20) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, d);
            else             step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, d);
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
